// File: rtl/layer2_pool_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer2_pool_pkg
// Brief    : Shared lane/pixel types and lanewise helpers for Layer-2 pooling.
// Revision : 1.0
// ============================================================================
package layer2_pool_pkg;

   localparam int LANES  = 8;
   localparam int LANE_W = 16;
   localparam int BUS_W  = LANES * LANE_W;

   typedef logic signed [LANE_W-1:0] lane_t;
   typedef lane_t [LANES-1:0]        pix_t;

   // Both operands are lane_t, so the comparison is two's-complement.
   function automatic lane_t lane_max(input lane_t a, input lane_t b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/layer2_pool_max8.sv
`default_nettype none
// ============================================================================
// Module   : layer2_pool_max8
// Brief    : Combinational lanewise signed max of two 8x16-bit pixels.
// Revision : 1.0
// ============================================================================
module layer2_pool_max8
   import layer2_pool_pkg::*;
(
   input  logic [BUS_W-1:0] i_a,
   input  logic [BUS_W-1:0] i_b,
   output logic [BUS_W-1:0] o_max
);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign o_max[k*LANE_W +: LANE_W] = lane_max(lane_t'(i_a[k*LANE_W +: LANE_W]),
                                                  lane_t'(i_b[k*LANE_W +: LANE_W]));
   end

endmodule
`default_nettype wire

// File: rtl/layer2_relu_pool.sv
`default_nettype none
// ============================================================================
// Module   : layer2_relu_pool
// Brief    : 2x2 stride-2 max pooling over 8 signed lanes with optional ReLU.
//            Define LAYER2_POOL_RELU_EN to clamp negative pooled lanes to 0.
// Revision : 1.0
// ============================================================================
module layer2_relu_pool
   import layer2_pool_pkg::*;
#(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic [BUS_W-1:0] d_Data_TDATA,
   input  logic             d_Data_TVALID,
   output logic             d_Data_TREADY,
   output logic [BUS_W-1:0] e_Data_TDATA,
   output logic             e_Data_TVALID,
   input  logic             e_Data_TREADY,
   output logic             e_Data_TLAST
);

   localparam int COL_W  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int ROW_W  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int HALF_W = IMG_W / 2;
   localparam int LB_AW  = (HALF_W > 2) ? $clog2(HALF_W) : 1;

   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic [BUS_W-1:0] r_hreg;
   logic [BUS_W-1:0] r_lbuf [HALF_W];
   logic [BUS_W-1:0] r_out_data;
   logic             r_out_valid;
   logic             r_out_last;

   logic             w_accept;
   logic             w_col_end;
   logic             w_row_end;
   logic             w_load;
   logic [LB_AW-1:0] w_lb_idx;
   logic [BUS_W-1:0] w_lb_rd;
   logic [BUS_W-1:0] w_h;
   logic [BUS_W-1:0] w_pool;
   logic [BUS_W-1:0] w_out;

   // Ready only depends on the output slot, never on which beat is arriving.
   assign d_Data_TREADY = !r_out_valid || e_Data_TREADY;
   assign w_accept      = d_Data_TVALID && d_Data_TREADY;
   assign w_col_end     = (r_col == COL_W'(IMG_W - 1));
   assign w_row_end     = (r_row == ROW_W'(IMG_H - 1));
   assign w_load        = w_accept && r_col[0] && r_row[0];
   assign w_lb_idx      = LB_AW'(r_col >> 1);
   assign w_lb_rd       = r_lbuf[w_lb_idx];

   layer2_pool_max8 u_hmax (
      .i_a   (r_hreg),
      .i_b   (d_Data_TDATA),
      .o_max (w_h)
   );

   layer2_pool_max8 u_vmax (
      .i_a   (w_h),
      .i_b   (w_lb_rd),
      .o_max (w_pool)
   );

`ifdef LAYER2_POOL_RELU_EN
   for (genvar k = 0; k < LANES; k++) begin : g_relu
      assign w_out[k*LANE_W +: LANE_W] = w_pool[k*LANE_W + LANE_W - 1] ? '0
                                                                       : w_pool[k*LANE_W +: LANE_W];
   end
`else
   assign w_out = w_pool;
`endif

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_col       <= '0;
         r_row       <= '0;
         r_hreg      <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         if (w_accept) begin
            if (w_col_end) begin
               r_col <= '0;
               r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
            if (!r_col[0]) begin
               r_hreg <= d_Data_TDATA;
            end
         end
         // A load always wins over a drain so a simultaneous pair keeps TVALID high.
         if (w_load) begin
            r_out_data  <= w_out;
            r_out_valid <= 1'b1;
            r_out_last  <= w_col_end && w_row_end;
         end else if (e_Data_TREADY) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end
      end
   end

   // Line buffer is fully rewritten on every even row before it is read.
   always_ff @(posedge ap_clk) begin
      if (w_accept && r_col[0] && !r_row[0]) begin
         r_lbuf[w_lb_idx] <= w_h;
      end
   end

   assign e_Data_TDATA  = r_out_data;
   assign e_Data_TVALID = r_out_valid;
   assign e_Data_TLAST  = r_out_last;

endmodule
`default_nettype wire
